rx_deframer: RTL and testbench

- Receive-direction counterpart of the SPI-fed transmit path, used on the Econet line.
- Takes sampled line bits and does HDLC-style flag hunting, zero-bit destuffing, abort detection and LSB-first byte assembly.
- Delivers 16-bit status/data words to the SPI host through a single receive holding register (RHR), using a request/strobe handshake.
- FCS bytes pass through to the host unchecked.

---
 rtl/rx_deframer.sv | 161 ++++++++++++++++
 tb/tb_rx_deframer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_deframer.sv
// Purpose: HDLC-style receive deframer: flag hunt, zero destuffing, abort detect, LSB-first bytes to a host RHR.
// Latency: a word decided on a bit-strobe edge appears in spi_data one clk later.
// Backpressure: single holding register; a word arriving while it is full and unread is dropped and overrun sets.
module rx_deframer #(
    parameter int IDLE_ONES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxdata,
    input  logic        rx_bit_strobe,
    input  logic        enable,
    output logic [15:0] spi_data,
    output logic        spi_data_request,
    input  logic        spi_data_strobe,
    output logic        overrun,
    output logic        frame_active,
    output logic        line_idle
);

    localparam int OW = $clog2(IDLE_ONES + 1);

    typedef enum logic [1:0] {HUNT, SYNC, DATA} state_t;

    state_t      state;
    logic [OW-1:0] ones;
    logic [2:0]  bitcnt;
    logic [7:0]  shreg;
    logic [7:0]  pend;
    logic        pend_vld;
    logic        push_vld;
    logic [15:0] push_word;
    logic        rhr_full;
    logic        strb_q;
    logic        strb_qq;

    logic          is_data;
    logic          is_flag;
    logic          is_abort;
    logic          byte_done;
    logic [7:0]    byte_new;
    logic [OW-1:0] ones_nxt;
    logic          consume;

    // Bit classification. A bit arriving after five 1s is never data: it is
    // either a stuffed 0, or part of a flag/abort. This leaves exactly six
    // flag bits (leading 0 + five 1s) counted as data, so bitcnt==6 at a flag
    // means the frame ended on an octet boundary.
    always_comb begin
        is_data   = (ones < OW'(5));
        is_flag   = !rxdata && (ones == OW'(6));
        is_abort  = rxdata && (ones == OW'(6));
        byte_done = is_data && (bitcnt == 3'd7);
        byte_new  = {rxdata, shreg[7:1]};
        if (!rxdata)
            ones_nxt = '0;
        else if (ones == OW'(IDLE_ONES))
            ones_nxt = ones;
        else
            ones_nxt = ones + OW'(1);
        consume = strb_q && !strb_qq;
    end

    // Bit engine, frame state machine and receive holding register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= HUNT;
            ones      <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
            pend      <= '0;
            pend_vld  <= 1'b0;
            push_vld  <= 1'b0;
            push_word <= '0;
            rhr_full  <= 1'b0;
            spi_data  <= '0;
            overrun   <= 1'b0;
            strb_q    <= 1'b0;
            strb_qq   <= 1'b0;
        end else begin
            strb_q  <= spi_data_strobe;
            strb_qq <= strb_q;
            if (!enable) begin
                state    <= HUNT;
                ones     <= '0;
                bitcnt   <= '0;
                pend_vld <= 1'b0;
                push_vld <= 1'b0;
                rhr_full <= 1'b0;
                overrun  <= 1'b0;
            end else begin
                push_vld <= 1'b0;
                if (rx_bit_strobe) begin
                    ones <= ones_nxt;
                    if (is_data) begin
                        shreg  <= byte_new;
                        bitcnt <= bitcnt + 3'd1;
                    end
                    case (state)
                        HUNT: begin
                            if (is_flag) begin
                                state    <= SYNC;
                                bitcnt   <= '0;
                                pend_vld <= 1'b0;
                            end
                        end
                        SYNC: begin
                            if (is_abort) begin
                                state <= HUNT;
                            end else if (is_flag) begin
                                bitcnt <= '0;
                            end else if (byte_done) begin
                                state    <= DATA;
                                pend     <= byte_new;
                                pend_vld <= 1'b1;
                            end
                        end
                        DATA: begin
                            if (is_abort) begin
                                push_vld  <= 1'b1;
                                push_word <= 16'hA000;
                                pend_vld  <= 1'b0;
                                state     <= HUNT;
                            end else if (is_flag) begin
                                push_vld <= 1'b1;
                                if (bitcnt == 3'd6 && pend_vld)
                                    push_word <= {8'hC0, pend};
                                else
                                    push_word <= 16'hA000;
                                pend_vld <= 1'b0;
                                bitcnt   <= '0;
                                state    <= SYNC;
                            end else if (byte_done) begin
                                push_vld  <= pend_vld;
                                push_word <= {8'h40, pend};
                                pend      <= byte_new;
                                pend_vld  <= 1'b1;
                            end
                        end
                        default: state <= HUNT;
                    endcase
                end
                // A read on the same edge as a load frees the slot for it.
                if (push_vld) begin
                    if (!rhr_full || consume) begin
                        spi_data <= push_word;
                        rhr_full <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end else if (consume) begin
                    rhr_full <= 1'b0;
                end
            end
        end
    end

    assign spi_data_request = rhr_full;
    assign frame_active     = (state == DATA);
    assign line_idle        = (ones == OW'(IDLE_ONES));

endmodule

// File: tb/tb_rx_deframer.sv
module tb_rx_deframer;

    logic        clk = 1'b0;
    logic        reset;
    logic        rxdata;
    logic        rx_bit_strobe;
    logic        enable;
    logic [15:0] spi_data;
    logic        spi_data_request;
    logic        spi_data_strobe;
    logic        overrun;
    logic        frame_active;
    logic        line_idle;

    int errors = 0;
    int checks = 0;
    int tx_ones = 0;

    rx_deframer #(.IDLE_ONES(15)) dut (
        .clk(clk),
        .reset(reset),
        .rxdata(rxdata),
        .rx_bit_strobe(rx_bit_strobe),
        .enable(enable),
        .spi_data(spi_data),
        .spi_data_request(spi_data_request),
        .spi_data_strobe(spi_data_strobe),
        .overrun(overrun),
        .frame_active(frame_active),
        .line_idle(line_idle)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One line bit; optionally raise the host read strobe together with it.
    task automatic send_bit(input logic b, input logic hs);
        rxdata = b;
        rx_bit_strobe = 1'b1;
        if (hs) spi_data_strobe = 1'b1;
        tick();
        rx_bit_strobe = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_flag();
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        tx_ones = 0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            send_bit(v[i], 1'b0);
            if (v[i]) tx_ones++; else tx_ones = 0;
            if (tx_ones == 5) begin
                send_bit(1'b0, 1'b0);
                tx_ones = 0;
            end
        end
    endtask

    task automatic read_word();
        spi_data_strobe = 1'b1;
        repeat (3) tick();
        spi_data_strobe = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        enable = 1'b1;
        rxdata = 1'b0;
        rx_bit_strobe = 1'b0;
        spi_data_strobe = 1'b0;
        tick();
        tick();
        checks++;
        if ({spi_data, spi_data_request, overrun, frame_active, line_idle} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h req=%b ovr=%b act=%b idle=%b want all 0",
                     spi_data, spi_data_request, overrun, frame_active, line_idle);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic_frame();
        send_flag();
        send_byte(8'h41);
        checks++;
        if (frame_active !== 1'b1) begin
            errors++; $display("FAIL t1_active: got %b want 1", frame_active);
        end
        send_byte(8'h00);
        checks++;
        if (spi_data_request !== 1'b1 || spi_data !== 16'h4041) begin
            errors++; $display("FAIL t1_word0: got req=%b data=%h want req=1 data=4041", spi_data_request, spi_data);
        end
        read_word();
        checks++;
        if (spi_data_request !== 1'b0) begin
            errors++; $display("FAIL t1_req_drop0: got %b want 0", spi_data_request);
        end
        send_flag();
        checks++;
        if (spi_data_request !== 1'b1 || spi_data !== 16'hC000) begin
            errors++; $display("FAIL t1_word1: got req=%b data=%h want req=1 data=C000", spi_data_request, spi_data);
        end
        read_word();
        checks++;
        if (spi_data_request !== 1'b0 || spi_data !== 16'hC000) begin
            errors++; $display("FAIL t1_req_drop1: got req=%b data=%h want req=0 data=C000", spi_data_request, spi_data);
        end
    endtask

    task automatic test_destuff();
        send_flag();
        send_byte(8'h1F);
        send_flag();
        checks++;
        if (spi_data_request !== 1'b1 || spi_data !== 16'hC01F) begin
            errors++; $display("FAIL t2_destuff: got req=%b data=%h want req=1 data=C01F", spi_data_request, spi_data);
        end
        read_word();
    endtask

    task automatic test_abort();
        send_flag();
        send_byte(8'h55);
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
        checks++;
        if (spi_data_request !== 1'b1 || spi_data !== 16'hA000) begin
            errors++; $display("FAIL t3_abort_word: got req=%b data=%h want req=1 data=A000", spi_data_request, spi_data);
        end
        checks++;
        if (frame_active !== 1'b0) begin
            errors++; $display("FAIL t3_abort_hunt: got active=%b want 0", frame_active);
        end
        read_word();
        send_flag();
        send_flag();
        checks++;
        if (spi_data_request !== 1'b0 || frame_active !== 1'b0) begin
            errors++; $display("FAIL t3_empty_frame: got req=%b active=%b want 0 0", spi_data_request, frame_active);
        end
    endtask

    task automatic test_overrun();
        send_flag();
        send_byte(8'h12);
        send_byte(8'h34);
        send_flag();
        checks++;
        if (spi_data !== 16'h4012 || spi_data_request !== 1'b1 || overrun !== 1'b1) begin
            errors++; $display("FAIL t4_overrun: got data=%h req=%b ovr=%b want 4012 1 1", spi_data, spi_data_request, overrun);
        end
        tick();
        tick();
        checks++;
        if (overrun !== 1'b1) begin
            errors++; $display("FAIL t4_sticky: got %b want 1", overrun);
        end
        enable = 1'b0;
        tick();
        enable = 1'b1;
        checks++;
        if (overrun !== 1'b0 || spi_data_request !== 1'b0 || frame_active !== 1'b0) begin
            errors++; $display("FAIL t4_disable: got ovr=%b req=%b act=%b want 0 0 0", overrun, spi_data_request, frame_active);
        end
    endtask

    task automatic test_misaligned_idle();
        send_flag();
        send_byte(8'h12);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
        // Closing flag: the 4th one completes a byte and releases 0x12.
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        checks++;
        if (spi_data_request !== 1'b1 || spi_data !== 16'h4012) begin
            errors++; $display("FAIL t5_spill: got req=%b data=%h want req=1 data=4012", spi_data_request, spi_data);
        end
        read_word();
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        checks++;
        if (spi_data_request !== 1'b1 || spi_data !== 16'hA000 || overrun !== 1'b0) begin
            errors++; $display("FAIL t5_misaligned: got req=%b data=%h ovr=%b want 1 A000 0", spi_data_request, spi_data, overrun);
        end
        read_word();
        for (int i = 0; i < 14; i++) send_bit(1'b1, 1'b0);
        checks++;
        if (line_idle !== 1'b0) begin
            errors++; $display("FAIL t5_idle14: got %b want 0", line_idle);
        end
        send_bit(1'b1, 1'b0);
        checks++;
        if (line_idle !== 1'b1 || spi_data_request !== 1'b0) begin
            errors++; $display("FAIL t5_idle15: got idle=%b req=%b want 1 0", line_idle, spi_data_request);
        end
        send_bit(1'b0, 1'b0);
        checks++;
        if (line_idle !== 1'b0) begin
            errors++; $display("FAIL t5_idle_clear: got %b want 0", line_idle);
        end
    endtask

    task automatic test_back_to_back();
        send_flag();
        send_byte(8'h12);
        send_byte(8'h34);
        checks++;
        if (spi_data !== 16'h4012 || spi_data_request !== 1'b1) begin
            errors++; $display("FAIL t6_pre: got data=%h req=%b want 4012 1", spi_data, spi_data_request);
        end
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        tx_ones = 0;
        checks++;
        if (spi_data !== 16'hC034 || spi_data_request !== 1'b1 || overrun !== 1'b0) begin
            errors++; $display("FAIL t6_same_edge: got data=%h req=%b ovr=%b want C034 1 0", spi_data, spi_data_request, overrun);
        end
        spi_data_strobe = 1'b0;
        tick();
        send_byte(8'h56);
        send_byte(8'h78);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        checks++;
        if (spi_data !== 16'hC034 || overrun !== 1'b1 || frame_active !== 1'b1) begin
            errors++; $display("FAIL t6_pre_reset: got data=%h ovr=%b act=%b want C034 1 1", spi_data, overrun, frame_active);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({spi_data, spi_data_request, overrun, frame_active, line_idle} !== 20'h0) begin
            errors++;
            $display("FAIL t6_async_reset: got data=%h req=%b ovr=%b act=%b idle=%b want all 0",
                     spi_data, spi_data_request, overrun, frame_active, line_idle);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_destuff();
        test_abort();
        test_overrun();
        test_misaligned_idle();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
